// File: rtl/idmemory_lsu.sv
// idmemory_lsu: RISC-V byte/half/word load-store front end over a DEPTH x 32 word array,
// one request in flight, response pulse LATENCY cycles after accept. Optional: IDMEM_FAULT_EN.
module idmemory_lsu #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [1:0]  reqSize,
   input  logic        reqUnsigned,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqWData,
   output logic        respValid,
   output logic [31:0] respRData,
   output logic        respFault
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   hold_q, hold_d;

   logic          accept;
   logic          req_fault;
   logic [AW-1:0] word_idx;
   logic [3:0]    byte_en;
   logic [31:0]   wr_lanes;
   logic [31:0]   load_result;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   rword_q;
   logic          write_q;
   logic          unsigned_q;
   logic          fault_q;
   logic [1:0]    size_q;
   logic [1:0]    lane_q;

   function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic uns);
      logic signed [7:0]  sb;
      logic signed [31:0] sw;
      sb = b;
      sw = sb;
      return uns ? {24'h0, b} : $unsigned(sw);
   endfunction

   function automatic logic [31:0] extend_half(input logic [15:0] h, input logic uns);
      logic signed [15:0] sh;
      logic signed [31:0] sw;
      sh = h;
      sw = sh;
      return uns ? {16'h0, h} : $unsigned(sw);
   endfunction

   assign reqReady  = (state_q != WAIT);
   assign respValid = (state_q == DONE);
   assign accept    = reqValid && reqReady && !reset;
   assign word_idx  = reqAddr[AW+1:2];

`ifdef IDMEM_FAULT_EN
   logic misaligned;
   logic out_of_range;

   always_comb begin
      misaligned   = ((reqSize == 2'b01) && reqAddr[0]) ||
                     (reqSize[1] && (reqAddr[1:0] != 2'b00));
      out_of_range = |reqAddr[31:AW+2];
      req_fault    = misaligned || out_of_range;
   end

   assign respFault = (state_q == DONE) && fault_q;
`else
   // Without fault checking, high address bits simply alias onto the array.
   logic unused_addr_hi;
   assign unused_addr_hi = ^reqAddr[31:AW+2];
   assign req_fault      = 1'b0;
   assign respFault      = 1'b0;
`endif

   // Store lane steering: data replicated across lanes, byte enables pick the target.
   always_comb begin
      byte_en  = 4'b1111;
      wr_lanes = reqWData;
      if (reqSize == 2'b00) begin
         byte_en  = 4'b0001 << reqAddr[1:0];
         wr_lanes = {4{reqWData[7:0]}};
      end else if (reqSize == 2'b01) begin
         byte_en  = reqAddr[1] ? 4'b1100 : 4'b0011;
         wr_lanes = {2{reqWData[15:0]}};
      end
   end

   always_comb begin
      load_result = 32'h0;
      if (!write_q && !fault_q) begin
         case (size_q)
            2'b00:   load_result = extend_byte(rword_q[{lane_q, 3'b000} +: 8], unsigned_q);
            2'b01:   load_result = extend_half(lane_q[1] ? rword_q[31:16] : rword_q[15:0],
                                               unsigned_q);
            default: load_result = rword_q;
         endcase
      end
   end

   assign respRData = (state_q == DONE) ? load_result : hold_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = respRData;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               if (LATENCY > 1) begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end else begin
                  state_d = DONE;
               end
            end
         end
         WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         hold_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   // Array port and captured request: written/read on the accepting edge only.
   always_ff @(posedge clk) begin
      if (accept) begin
         write_q    <= reqWrite;
         size_q     <= reqSize;
         unsigned_q <= reqUnsigned;
         lane_q     <= reqAddr[1:0];
         fault_q    <= req_fault;
         rword_q    <= mem[word_idx];
      end
      if (accept && reqWrite && !req_fault) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem[word_idx][i*8 +: 8] <= wr_lanes[i*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_idmemory_lsu.sv
// Bench for idmemory_lsu: three instances (LATENCY 1, 3, 4), directed vector table,
// reset corner sequences and randomized traffic against a byte-array reference model.
`timescale 1ns/1ps
module tb_idmemory_lsu;

   localparam int DEPTH = 256;
   localparam int ND    = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst        [ND];
   logic        req_valid  [ND];
   logic        req_ready  [ND];
   logic        req_write  [ND];
   logic [1:0]  req_size   [ND];
   logic        req_uns    [ND];
   logic [31:0] req_addr   [ND];
   logic [31:0] req_wdata  [ND];
   logic        resp_valid [ND];
   logic [31:0] resp_rdata [ND];
   logic        resp_fault [ND];

   for (genvar g = 0; g < ND; g++) begin : g_dut
      idmemory_lsu #(
         .DEPTH   (DEPTH),
         .LATENCY ((g == 0) ? 1 : (g == 1) ? 3 : 4)
      ) u_dut (
         .clk         (clk),
         .reset       (rst[g]),
         .reqValid    (req_valid[g]),
         .reqReady    (req_ready[g]),
         .reqWrite    (req_write[g]),
         .reqSize     (req_size[g]),
         .reqUnsigned (req_uns[g]),
         .reqAddr     (req_addr[g]),
         .reqWData    (req_wdata[g]),
         .respValid   (resp_valid[g]),
         .respRData   (resp_rdata[g]),
         .respFault   (resp_fault[g])
      );
   end

   int checks = 0;
   int errors = 0;

   // Reference memory: plain little-endian byte array per instance.
   logic [7:0] mbytes [ND][DEPTH*4];

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 3 : 4;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic void model_op(input int d, input logic wr, input logic [1:0] sz,
                                    input logic uns, input logic [31:0] addr,
                                    input logic [31:0] wd, output logic [31:0] rd,
                                    output logic flt);
      int          nb;
      logic [31:0] a;
      logic [31:0] v;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      rd  = 32'h0;
      flt = 1'b0;
`ifdef IDMEM_FAULT_EN
      if ((addr % nb) != 0 || (addr / 4) >= DEPTH) begin
         flt = 1'b1;
         return;
      end
      a = addr;
`else
      a = addr - (addr % nb);
      a = a % (DEPTH * 4);
`endif
      if (wr) begin
         for (int i = 0; i < nb; i++) mbytes[d][a + i] = wd[i*8 +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < nb; i++) v = v | (32'(mbytes[d][a + i]) << (8 * i));
         if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
         rd = v;
      end
   endfunction

   task automatic xact(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input string nm,
                       output logic [31:0] rd, output logic flt);
      int   n;
      int   lat;
      logic ready_bad;
      lat       = lat_of(d);
      rd        = 32'h0;
      flt       = 1'b0;
      ready_bad = 1'b0;
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_size[d]  = sz;
      req_uns[d]   = uns;
      req_addr[d]  = addr;
      req_wdata[d] = wd;
      n = 0;
      while (req_ready[d] !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (req_ready[d] !== 1'b1) begin
         chk({nm, " accept"}, {31'h0, req_ready[d]}, 32'h1);
         req_valid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      // Scramble inputs: the transaction must use the values captured at accept.
      req_valid[d] = 1'b0;
      req_write[d] = 1'($urandom);
      req_size[d]  = 2'($urandom);
      req_uns[d]   = 1'($urandom);
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      n = 1;
      while (resp_valid[d] !== 1'b1 && n <= lat + 2) begin
         if (req_ready[d] !== 1'b0) ready_bad = 1'b1;
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, 32'(n), 32'(lat));
      chk({nm, " ready_low_in_wait"}, {31'h0, ready_bad}, 32'h0);
      rd  = resp_rdata[d];
      flt = resp_fault[d];
   endtask

   task automatic op(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input string nm,
                     input logic use_exp, input logic [31:0] exp_rd, input logic exp_flt);
      logic [31:0] mrd, rd;
      logic        mflt, flt;
      model_op(d, wr, sz, uns, addr, wd, mrd, mflt);
      xact(d, wr, sz, uns, addr, wd, nm, rd, flt);
      if (use_exp) begin
         mrd  = exp_rd;
         mflt = exp_flt;
      end
      chk({nm, " rdata"}, rd, mrd);
      chk({nm, " fault"}, {31'h0, flt}, {31'h0, mflt});
   endtask

   typedef struct packed {
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_flt;
   } vec_t;

   function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input logic exp_flt);
      vec_t v;
      v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
      v.exp_rd = exp_rd; v.exp_flt = exp_flt;
      return v;
   endfunction

   vec_t tbl [$];

   initial begin
      logic        wr, uns, seen;
      logic [1:0]  sz;
      logic [31:0] addr;

      for (int d = 0; d < ND; d++) begin
         rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
         req_uns[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
      end

      // store:1/load:0, size, unsigned, addr, wdata, expected rdata, expected fault
      tbl.push_back(mk(1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 32'h0, 0));
      tbl.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0));
      tbl.push_back(mk(1, 2'd2, 0, 32'h20,  32'h11223344, 32'h0, 0));
      tbl.push_back(mk(1, 2'd0, 0, 32'h21,  32'h000000A5, 32'h0, 0));
      tbl.push_back(mk(1, 2'd1, 0, 32'h22,  32'h00008001, 32'h0, 0));
      tbl.push_back(mk(0, 2'd2, 0, 32'h20,  32'h0,        32'h8001A544, 0));
      tbl.push_back(mk(0, 2'd0, 0, 32'h21,  32'h0,        32'hFFFFFFA5, 0));
      tbl.push_back(mk(0, 2'd0, 1, 32'h21,  32'h0,        32'h000000A5, 0));
      tbl.push_back(mk(0, 2'd1, 0, 32'h22,  32'h0,        32'hFFFF8001, 0));
      tbl.push_back(mk(0, 2'd1, 1, 32'h22,  32'h0,        32'h00008001, 0));
      tbl.push_back(mk(0, 2'd3, 1, 32'h20,  32'h0,        32'h8001A544, 0));
`ifdef IDMEM_FAULT_EN
      tbl.push_back(mk(0, 2'd2, 0, 32'h13,  32'h0,        32'h0, 1));
      tbl.push_back(mk(1, 2'd1, 0, 32'h21,  32'h0000FFFF, 32'h0, 1));
      tbl.push_back(mk(0, 2'd2, 0, 32'h400, 32'h0,        32'h0, 1));
      tbl.push_back(mk(0, 2'd2, 0, 32'h20,  32'h0,        32'h8001A544, 0));
`else
      tbl.push_back(mk(1, 2'd2, 0, 32'h403, 32'hCAFEF00D, 32'h0, 0));
      tbl.push_back(mk(0, 2'd2, 0, 32'h000, 32'h0,        32'hCAFEF00D, 0));
      tbl.push_back(mk(0, 2'd1, 1, 32'h403, 32'h0,        32'h0000CAFE, 0));
`endif

      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("d%0d reset ready", d), {31'h0, req_ready[d]}, 32'h1);
         chk($sformatf("d%0d reset valid", d), {31'h0, resp_valid[d]}, 32'h0);
         chk($sformatf("d%0d reset rdata", d), resp_rdata[d], 32'h0);
         chk($sformatf("d%0d reset fault", d), {31'h0, resp_fault[d]}, 32'h0);
         rst[d] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("d%0d idle ready", d), {31'h0, req_ready[d]}, 32'h1);
         chk($sformatf("d%0d idle valid", d), {31'h0, resp_valid[d]}, 32'h0);
         chk($sformatf("d%0d idle rdata", d), resp_rdata[d], 32'h0);
      end

      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < tbl.size(); i++) begin
            op(d, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
               $sformatf("d%0d vec%0d", d, i), 1'b1, tbl[i].exp_rd, tbl[i].exp_flt);
         end
      end

      // Reset wins over a simultaneous request: the store must not land.
      op(0, 1, 2'd2, 0, 32'h40, 32'h12345678, "rstreq SW", 1'b1, 32'h0, 1'b0);
      rst[0] = 1'b1;
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'd2;
      req_addr[0] = 32'h40; req_wdata[0] = 32'hFFFFFFFF;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (resp_valid[0] !== 1'b0) seen = 1'b1;
      end
      req_valid[0] = 1'b0;
      rst[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (resp_valid[0] !== 1'b0) seen = 1'b1;
      end
      chk("rstreq no response", {31'h0, seen}, 32'h0);
      op(0, 0, 2'd2, 0, 32'h40, 32'h0, "rstreq LW", 1'b1, 32'h12345678, 1'b0);

      // Reset two cycles after a LATENCY=4 load accept drops its response.
      op(2, 1, 2'd2, 0, 32'h30, 32'h55, "midrst SW", 1'b1, 32'h0, 1'b0);
      req_valid[2] = 1'b1; req_write[2] = 1'b0; req_size[2] = 2'd2;
      req_uns[2] = 1'b0; req_addr[2] = 32'h30;
      chk("midrst ready", {31'h0, req_ready[2]}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0;
      seen = (resp_valid[2] !== 1'b0);
      @(negedge clk);
      if (resp_valid[2] !== 1'b0) seen = 1'b1;
      rst[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (resp_valid[2] !== 1'b0) seen = 1'b1;
      end
      chk("midrst ready in reset", {31'h0, req_ready[2]}, 32'h1);
      chk("midrst rdata in reset", resp_rdata[2], 32'h0);
      rst[2] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (resp_valid[2] !== 1'b0) seen = 1'b1;
      end
      chk("midrst dropped response", {31'h0, seen}, 32'h0);
      op(2, 0, 2'd2, 0, 32'h30, 32'h0, "midrst LW", 1'b1, 32'h00000055, 1'b0);

      // Randomized traffic in a pre-filled window against the byte model.
      for (int d = 0; d < ND; d++) begin
         for (int w = 0; w < 32; w++) begin
            op(d, 1, 2'd2, 0, 32'h100 + 32'(4 * w), $urandom, "fill", 1'b0, 32'h0, 1'b0);
         end
         for (int k = 0; k < 60; k++) begin
            wr   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = 32'h100 + 32'($urandom_range(0, 127));
`ifdef IDMEM_FAULT_EN
            if ($urandom_range(0, 7) == 0) addr = addr + 32'h400 * 32'($urandom_range(1, 4));
`else
            addr = addr + 32'h400 * 32'($urandom_range(0, 3));
`endif
            op(d, wr, sz, uns, addr, $urandom, $sformatf("d%0d rand%0d", d, k),
               1'b0, 32'h0, 1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/idmemory_lsu.md
# idmemory_lsu

Parametrised, latency-configurable instruction/data memory with a RISC-V load/store front end. It accepts one byte-addressed request at a time over a valid/ready handshake. It performs byte, half and word stores with lane masking, and byte, half and word loads with sign or zero extension. Each request returns a single-cycle response pulse. It sits between the core's memory stage and an on-chip M10K word array and replaces the fixed 256x32 word-addressed memory.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; power of two, 4 to 65536.
- LATENCY, 1: cycles from the accepting edge to the response; 1 to 8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- reqValid  in  1  request present.
- reqReady  out  1  block can accept a request this cycle.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- reqUnsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- reqAddr  in  32  byte address.
- reqWData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- respValid  out  1  one-cycle response pulse.
- respRData  out  32  load result; 0 for stores and faults; holds between responses.
- respFault  out  1  valid with respValid: misaligned or out-of-range access.

## Operation
- A request is accepted on a rising edge where reqValid && reqReady.
- Word index is reqAddr[31:2]. Lane is reqAddr[1:0].
- FSM states:
  - IDLE: reqReady = 1. On accept, go to WAIT if LATENCY > 1, otherwise go to DONE.
  - WAIT: reqReady = 0. The counter runs from LATENCY-1 down. Go to DONE when the counter reaches 1.
  - DONE: respValid = 1 and reqReady = 1. On accept, go to WAIT or DONE as in IDLE. Otherwise go to IDLE.
- Fault (only with IDMEM_FAULT_EN):
  - Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Out of range: word index >= DEPTH.
  - A faulting request makes no array access. Its response has respFault = 1 and respRData = 0.
- Store behaviour:
  - The array is written on the accepting edge.
  - Byte store writes lane addr[1:0] with wdata[7:0].
  - Half store writes lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0].
  - Word store writes all four lanes.
  - Unselected lanes are unchanged.
  - The response has respRData = 0.
- Load behaviour:
  - The word is read on the accepting edge.
  - The selected byte or half is shifted down to bit 0 and then extended per reqUnsigned.
  - Word loads ignore reqUnsigned.
- Transactions are strictly ordered. A load accepted after a store returns the stored data.
- Request inputs are captured at accept. Later changes to the inputs have no effect on the transaction in flight.

## Timing
- Reset values:
  - State is IDLE and the counter is 0.
  - reqReady = 1, respValid = 0, respRData = 0, respFault = 0.
  - Array contents are not reset.
- Latency:
  - For a request accepted at edge N, respValid is high from edge N+LATENCY-1 to edge N+LATENCY, i.e. during cycle N+LATENCY.
  - respRData and respFault are valid in that same cycle.
- Throughput: one request per LATENCY cycles. A back-to-back request is accepted on the edge that ends the DONE cycle.
- There is no response backpressure. The consumer must sample respValid when it is high.
- Reset mid-transaction:
  - The in-flight response is dropped and no respValid is produced.
  - A store already accepted remains committed.
- If reset and reqValid are both high, reset wins and no request is accepted.

## Configuration
- IDMEM_FAULT_EN defined:
  - Misalignment and range checks are performed as described in Operation.
  - respFault is driven.
- IDMEM_FAULT_EN undefined:
  - respFault is tied 0.
  - Address low bits below the access size are ignored (the address is aligned down).
  - The word index wraps modulo DEPTH.
  - Every request accesses the array.

## Test plan
- Reset, then idle: reqReady = 1, respValid = 0, respRData = 0x00000000 during reset and afterwards.
- Word round trip (LATENCY = 1, then LATENCY = 3):
  - Stimulus: SW 0xDEADBEEF to 0x10, then LW from 0x10.
  - Required: LW response 0xDEADBEEF, respFault = 0.
  - Required: respValid exactly LATENCY cycles after each accept.
  - Required: reqReady low throughout WAIT.
- Lane masking and extension:
  - Stimulus: SW 0x11223344 to 0x20, then SB 0xA5 to 0x21, then SH 0x8001 to 0x22.
  - Required: LW 0x20 returns 0x8001A544.
  - Required: LB 0x21 returns 0xFFFFFFA5 and LBU 0x21 returns 0x000000A5.
  - Required: LH 0x22 returns 0xFFFF8001 and LHU 0x22 returns 0x00008001.
- Faults (IDMEM_FAULT_EN defined, DEPTH = 256):
  - Stimulus: LW 0x13, SH 0x21, LW 0x400.
  - Required: each response has respFault = 1 and respRData = 0.
  - Required: a following LW 0x20 confirms memory is unchanged.
- Wrap and align (IDMEM_FAULT_EN undefined, DEPTH = 256):
  - Stimulus: SW 0xCAFEF00D to 0x403.
  - Required: LW 0x000 returns 0xCAFEF00D and respFault stays 0.
- Reset mid-transaction (LATENCY = 4):
  - Stimulus: SW 0x55 to 0x30, then LW 0x30, then assert reset 2 cycles after the LW accept.
  - Required: no respValid for the LW.
  - Required: after reset, LW 0x30 returns 0x00000055.
